// File: rtl/alu_pkg.sv
// Shared constants, state encoding and control decode for the bit-serial ALU sequencer.
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // 1-bit slice operation select
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

    // Slice controls plus what the flag logic needs to know about the op.
    typedef struct packed {
        logic       ainv;
        logic       binv;
        logic [1:0] op;
        logic       arith;  // ADD/SUB/SLT: carry and overflow are meaningful
        logic       slt;    // result collapses to the sign-corrected compare bit
        logic       valid;  // supported control code
    } slice_ctl_t;

    function automatic slice_ctl_t decode_ctrl(input logic [3:0] ctrl);
        slice_ctl_t c;
        c = '0;
        c.op = OP_AND;
        case (ctrl)
            ALU_AND: begin c.valid = 1'b1; end
            ALU_OR:  begin c.valid = 1'b1; c.op = OP_OR; end
            ALU_ADD: begin c.valid = 1'b1; c.op = OP_ADD; c.arith = 1'b1; end
            ALU_SUB: begin c.valid = 1'b1; c.op = OP_ADD; c.arith = 1'b1; c.binv = 1'b1; end
            ALU_SLT: begin
                c.valid = 1'b1; c.op = OP_ADD; c.arith = 1'b1; c.binv = 1'b1; c.slt = 1'b1;
            end
            ALU_NOR: begin c.valid = 1'b1; c.ainv = 1'b1; c.binv = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: AND / OR / full-add / less pass-through, with A/B invert.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       ainv_i,
    input  logic       binv_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic [1:0] op_i,
    output logic       res_o,
    output logic       cout_o
);

    logic a_eff;
    logic b_eff;

    // Invert operands, then select the requested function; carry is always the adder carry.
    always_comb begin
        a_eff  = a_i ^ ainv_i;
        b_eff  = b_i ^ binv_i;
        cout_o = (a_eff & b_eff) | (a_eff & cin_i) | (b_eff & cin_i);
        case (op_i)
            OP_AND:  res_o = a_eff & b_eff;
            OP_OR:   res_o = a_eff | b_eff;
            OP_ADD:  res_o = a_eff ^ b_eff ^ cin_i;
            default: res_o = less_i;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial 32-bit ALU: steps one slice across all bits LSB first, then resolves flags/SLT.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             cout_o
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             carry_q;
    logic             cin_msb_q;
    slice_ctl_t       ctl_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             cout_q;

    slice_ctl_t       start_ctl;
    logic             slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] fin_result;
    logic             fin_ovf;
    logic             fin_cout;

    // Operand shift registers present the current bit at position 0.
    alu_bit_slice u_slice (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .ainv_i (ctl_q.ainv),
        .binv_i (ctl_q.binv),
        .cin_i  (carry_q),
        .less_i (1'b0),
        .op_i   (ctl_q.op),
        .res_o  (slice_res),
        .cout_o (slice_cout)
    );

    // Decode for the accepting edge and final result/flag resolution for the FIN edge.
    always_comb begin
        start_ctl  = decode_ctrl(ctrl_i);
        // In FIN carry_q holds the carry out of the MSB.
        fin_ovf    = ctl_q.arith & (cin_msb_q ^ carry_q);
        fin_cout   = ctl_q.arith & carry_q;
        fin_result = res_sh_q;
        if (!ctl_q.valid) begin
            fin_result = '0;
        end else if (ctl_q.slt) begin
            fin_result    = '0;
            fin_result[0] = res_sh_q[WIDTH-1] ^ fin_ovf;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_sh_q  <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            ctl_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= src1_i;
                        b_q     <= src2_i;
                        ctl_q   <= start_ctl;
                        // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                        carry_q <= start_ctl.arith & start_ctl.binv;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    res_sh_q <= {slice_res, res_sh_q[WIDTH-1:1]};
                    carry_q  <= slice_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        cin_msb_q <= carry_q;
                        done_q    <= 1'b1;
                        state_q   <= FIN;
                    end
                end
                FIN: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    result_q <= fin_result;
                    zero_q   <= (fin_result == '0);
                    ovf_q    <= fin_ovf;
                    cout_q   <= fin_cout;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign cout_o     = cout_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: driver pushes model results, monitor checks on done_o.
module tb_alu_serial_seq;

    localparam int unsigned WIDTH = 32;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        v;
        logic        c;
        int          done_at;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        cout;

    int   checks;
    int   errors;
    int   cyc;
    int   acc;
    exp_t sb[$];
    logic [31:0] last_res;

    alu_serial_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .ctrl_i     (ctrl),
        .src1_i     (src1),
        .src2_i     (src2),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .zero_o     (zero),
        .overflow_o (ovf),
        .cout_o     (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain 33-bit arithmetic and signed compare.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        e.res = '0; e.v = 1'b0; e.c = 1'b0; e.done_at = 0;
        case (op)
            C_AND: e.res = a & b;
            C_OR:  e.res = a | b;
            C_NOR: e.res = ~(a | b);
            C_ADD: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[31:0];
                e.c   = s[32];
                e.v   = (a[31] == b[31]) && (s[31] != a[31]);
            end
            C_SUB, C_SLT: begin
                s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.c = s[32];
                e.v = (a[31] != b[31]) && (s[31] != a[31]);
                if (op == C_SUB) e.res = s[31:0];
                else             e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    // Issue one op; optionally record its expected response in the scoreboard.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        exp_t e;
        wait_idle();
        ctrl  = op;
        src1  = a;
        src2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
        // Operands may change after acceptance.
        src1  = $urandom;
        src2  = $urandom;
        ctrl  = 4'($urandom);
        if (push) begin
            e = model(op, a, b);
            e.done_at = acc + WIDTH;
            sb.push_back(e);
            last_res = e.res;
        end
    endtask

    // Monitor: on each done pulse, pop and compare timing, then the results one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_at);
                    chk("busy_in_fin", {31'd0, busy}, 32'd1);
                    @(posedge clk);
                    #1;
                    chk("result", result, e.res);
                    chk("zero", {31'd0, zero}, {31'd0, e.z});
                    chk("overflow", {31'd0, ovf}, {31'd0, e.v});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  codes [7];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prev;
        int          n;

        codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_NOR, 4'b1010};
        checks = 0; errors = 0; cyc = 0; last_res = '0;
        start = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, zero, ovf, cout}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        issue(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        issue(C_SUB, 32'h0000_0005, 32'h0000_0005, 1'b1);
        issue(C_SUB, 32'h8000_0000, 32'h0000_0001, 1'b1);
        issue(C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        issue(C_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        issue(C_SLT, 32'h1234_5678, 32'h1234_5678, 1'b1);
        issue(C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        issue(C_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        issue(C_NOR, 32'h0000_0000, 32'h0000_0000, 1'b1);
        issue(4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

        // Start pulses during RUN and FIN are ignored; result holds until this op's done.
        issue(C_ADD, 32'h0000_0001, 32'h0000_0002, 1'b1);
        wait_idle();
        prev = last_res;
        issue(C_OR, 32'h0101_0000, 32'h0000_0A0A, 1'b1);
        repeat (4) @(negedge clk);
        ctrl = C_NOR; src1 = '0; src2 = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_result", result, prev);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("fin_seen", {31'd0, done}, 32'd1);
        ctrl = C_AND; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Held start: back-to-back ops WIDTH+2 cycles apart.
        wait_idle();
        repeat (2) @(negedge clk);
        a = 32'h4000_0000; b = 32'h4000_0000;
        ctrl = C_ADD; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        begin
            exp_t e;
            e = model(C_ADD, a, b);
            e.done_at = acc + WIDTH;
            sb.push_back(e);
            e.done_at = acc + 2 * WIDTH + 2;
            sb.push_back(e);
        end
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart_busy", {31'd0, busy}, 32'd1);

        // Asynchronous reset mid-operation aborts with all outputs cleared.
        issue(C_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_flags", {29'd0, zero, ovf, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(C_SUB, 32'h0000_0010, 32'h0000_0020, 1'b1);

        // Randomized ops with biased operand patterns.
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                2: b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
                default: ;
            endcase
            issue(codes[$urandom_range(0, 6)], a, b, 1'b1);
        end

        // Drain the scoreboard.
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", sb.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
